// File: rtl/simple_circuit_pipe_if.sv
// Bundles the operand/result lanes, both valid/ready handshakes and the
// mismatch counter controls of simple_circuit_pipe.
interface simple_circuit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] INJ;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] G;
  logic [WIDTH-1:0] H;
  logic [WIDTH-1:0] MISMATCH;
  logic             CNT_CLR;
  logic [CNT_W-1:0] MISMATCH_CNT;
  logic             ERR;

  // The producer/consumer side that feeds beats in and drains results.
  modport master (
    output IN_VALID, A, B, C, INJ, OUT_READY, CNT_CLR,
    input  IN_READY, OUT_VALID, E, F, G, H, MISMATCH, MISMATCH_CNT, ERR
  );

  modport slave (
    input  IN_VALID, A, B, C, INJ, OUT_READY, CNT_CLR,
    output IN_READY, OUT_VALID, E, F, G, H, MISMATCH, MISMATCH_CNT, ERR
  );
endinterface

// File: rtl/simple_circuit_pipe.sv
// Two-stage valid/ready pipeline of the simple_circuit gate network across
// WIDTH lanes, with a golden check of H against A&B&C and a mismatch counter.
module simple_circuit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                 CLK,
  input logic                 RST,
  simple_circuit_pipe_if.slave bus
);
  logic             s1Valid_q;
  logic             s2Valid_q;
  logic [WIDTH-1:0] andOut_q;
  logic [WIDTH-1:0] orOut_q;
  logic [WIDTH-1:0] invOut_q;
  logic [WIDTH-1:0] cStage_q;
  logic [WIDTH-1:0] inj_q;

  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] f_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] mismatch_q;

  logic [WIDTH-1:0] intermediate1;
  logic [WIDTH-1:0] intermediate2;
  logic [WIDTH-1:0] h_d;
  logic [WIDTH-1:0] mismatch_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  logic s2Load;
  logic inFire;
  logic outFire;

  // Stage 2 may load whenever it is empty or its beat leaves this cycle.
  assign s2Load       = !s2Valid_q || bus.OUT_READY;
  assign bus.IN_READY = !s1Valid_q || s2Load;
  assign inFire       = bus.IN_VALID && bus.IN_READY;
  assign outFire      = s2Valid_q && bus.OUT_READY;

  always_comb begin
    intermediate1 = (orOut_q & invOut_q) ^ inj_q;
    intermediate2 = andOut_q | intermediate1;
    h_d           = intermediate2 & cStage_q;
    mismatch_d    = h_d ^ (andOut_q & cStage_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1Valid_q <= 1'b0;
      andOut_q  <= '0;
      orOut_q   <= '0;
      invOut_q  <= '0;
      cStage_q  <= '0;
      inj_q     <= '0;
    end else if (inFire) begin
      s1Valid_q <= 1'b1;
      andOut_q  <= bus.A & bus.B;
      orOut_q   <= bus.A | bus.C;
      invOut_q  <= ~bus.C;
      cStage_q  <= bus.C;
      inj_q     <= bus.INJ;
    end else if (s2Load) begin
      s1Valid_q <= 1'b0;
    end
  end

  // Result registers only change when a real beat moves in, so they hold under backpressure.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2Valid_q  <= 1'b0;
      e_q        <= '0;
      f_q        <= '0;
      g_q        <= '0;
      h_q        <= '0;
      mismatch_q <= '0;
    end else if (s2Load) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        e_q        <= andOut_q;
        f_q        <= orOut_q;
        g_q        <= invOut_q;
        h_q        <= h_d;
        mismatch_q <= mismatch_d;
      end
    end
  end

  // Clear takes priority over a coincident mismatch handshake.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (bus.CNT_CLR) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (outFire && (|mismatch_q)) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.OUT_VALID    = s2Valid_q;
  assign bus.E            = e_q;
  assign bus.F            = f_q;
  assign bus.G            = g_q;
  assign bus.H            = h_q;
  assign bus.MISMATCH     = mismatch_q;
  assign bus.MISMATCH_CNT = cnt_q;
  assign bus.ERR          = err_q;
endmodule
